idma_wdata_buf: RTL and testbench
=================================

# idma_wdata_buf

Write-data staging buffer for the iDMA write path. It accepts 256-bit beats plus byte strobes from the NPU-side write datapath through a valid/ready handshake. It presents them to the AXI write interface as a first-word-fall-through FIFO with flop-driven outputs (`wdata_fifo_empty_d`, `wdata_fifo_data_d`, `wdata_fifo_strb_d`), consumed by `wdata_fifo_pop`. The block also provides occupancy, almost-full and sticky error status for the DMA controller.

## Interface
- `AXI_DATA_WID`, 256, data beat width in bits
- `AXI_STRBW`, `AXI_DATA_WID/8`, strobe width
- `DEPTH`, 16, total beat capacity including the output stage; power of two, ≥ 4
- `AF_MARGIN`, 2, `almost_full` asserts when free slots ≤ `AF_MARGIN`
- `CNTW`, `$clog2(DEPTH+1)`, occupancy width

- `aclk` in 1: clock
- `aresetn` in 1: asynchronous active-low reset
- `wr_cfg_init` in 1: synchronous flush at the start of a new write command
- `in_valid` in 1: upstream beat valid
- `in_ready` out 1: buffer can accept a beat
- `in_data` in AXI_DATA_WID: upstream beat data
- `in_strb` in AXI_STRBW: upstream byte strobes
- `wdata_fifo_empty_d` out 1: head beat not present (registered)
- `wdata_fifo_pop` in 1: consume head beat
- `wdata_fifo_data_d` out AXI_DATA_WID: head beat data (registered)
- `wdata_fifo_strb_d` out AXI_STRBW: head beat strobes (registered)
- `fifo_cnt` out CNTW: beats held, 0..DEPTH
- `almost_full` out 1: `fifo_cnt ≥ DEPTH-AF_MARGIN` (registered)
- `ovf_err` out 1: sticky, push attempted while `in_ready` = 0 and `in_valid` = 1 for more than one cycle is legal; set only on an internal write while full (design-error guard)
- `udf_err` out 1: sticky, pop while `wdata_fifo_empty_d` = 1

## Operation
- Push = `in_valid & in_ready`. Pop = `wdata_fifo_pop & !wdata_fifo_empty_d`.
- Storage consists of a head output register plus a (DEPTH-1)-entry circular array with `rd_ptr` and `wr_ptr`. Both pointers wrap modulo DEPTH-1 through explicit compare, not power-of-two masking.
- Head refill priority:
  - If the head is empty, or popped this cycle, it loads the oldest array entry.
  - If the array is empty, it loads the pushed beat directly (bypass).
  - Otherwise the head goes empty.
- Beat order is strictly preserved. Data and strobes travel together unmodified.
- `in_ready = (fifo_cnt < DEPTH)`. It is derived from registered count only: no combinational path from `wdata_fifo_pop` to `in_ready`.
- `fifo_cnt` update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on both or neither.
- `wr_cfg_init` clears pointers, count, head valid and both error flags. It takes priority over a push and a pop in the same cycle; both are discarded. Data and strobe outputs hold their last values.
- A pop while empty is ignored (no state change) and sets `udf_err`.

## Timing
- Reset values: `in_ready` = 1, `wdata_fifo_empty_d` = 1, `wdata_fifo_data_d` = 0, `wdata_fifo_strb_d` = 0, `fifo_cnt` = 0, `almost_full` = 0, `ovf_err` = 0, `udf_err` = 0. Reset mid-transfer drops all held beats.
- Push-to-visible latency is 1 cycle. A push into an empty buffer at edge t gives `empty_d` = 0 with that beat's data after edge t.
- Back-to-back pops are sustainable at one beat per cycle with no bubbles while `fifo_cnt ≥ 2`.
- Simultaneous push and pop with `fifo_cnt` = 1: the head takes the pushed beat; `empty_d` stays 0.
- Full (`fifo_cnt` = DEPTH): `in_ready` = 0. A pop that cycle raises `in_ready` on the next cycle.
- `almost_full` and `fifo_cnt` are valid in the cycle after the causing edge.

## Structure
- Shared package `idma_pkg` holds `AXI_DATA_WID` and `AXI_STRBW` defaults and a `wbeat_t` struct {data, strb} used by the array and head register.
- One sub-module: `idma_fifo_mem`.
  - (DEPTH-1) × `wbeat_t` 1W1R array.
  - Asynchronous read.
  - No reset on storage.
- Pointer, count and head logic stay in `idma_wdata_buf`.

## Test plan
- Reset then a single push of data 0xA5..A5 with strb all-ones → `empty_d` falls the next cycle, head = 0xA5..A5; pop → `empty_d` = 1, `fifo_cnt` = 0.
- Push 16 incrementing beats with no pops → `fifo_cnt` = 16, `in_ready` = 0, `almost_full` = 1 from `cnt` = 14. Then 16 pops one per cycle → beats 0..15 in order with no bubble.
- Continuous push and pop at `fifo_cnt` = 1 for 100 cycles → `cnt` stays 1, outputs track input with a 1-cycle lag, no loss.
- Pop while empty → `udf_err` = 1 and sticky, `cnt` stays 0. Then `wr_cfg_init` → `udf_err` = 0.
- Fill 10 beats, assert `wr_cfg_init` together with push and pop → next cycle `cnt` = 0, `empty_d` = 1, `in_ready` = 1; the pushed beat is not delivered later.
- Pointer wrap: random push/pop for 1000 cycles against a scoreboard model → in-order delivery, and `cnt` matches the model every cycle.

Source files
------------

// File: rtl/idma_pkg.sv
// Shared iDMA definitions: default AXI write-data widths and the
// staged write-beat type carried through the write-data buffer.
package idma_pkg;

  localparam int unsigned AXI_DATA_WID_DFLT = 256;
  localparam int unsigned AXI_STRBW_DFLT    = AXI_DATA_WID_DFLT / 8;

  // One write beat: data plus its byte strobes, always moved together.
  typedef struct packed {
    logic [AXI_DATA_WID_DFLT-1:0] data;
    logic [AXI_STRBW_DFLT-1:0]    strb;
  } wbeat_t;

endpackage

// File: rtl/idma_fifo_mem.sv
// Storage array for the write-data buffer: ENTRIES x wbeat_t,
// one synchronous write port and one asynchronous read port, no reset.
module idma_fifo_mem
  import idma_pkg::*;
#(
  parameter int unsigned ENTRIES = 15,
  parameter int unsigned AW      = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  wbeat_t        wdata,
  input  logic [AW-1:0] raddr,
  output wbeat_t        rdata
);

  wbeat_t mem [ENTRIES];

  // Write a beat into the addressed slot; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/idma_wdata_buf.sv
// Write-data staging buffer: a registered head beat in front of a
// (DEPTH-1)-entry circular array, presented as a first-word-fall-through
// FIFO with flop-driven outputs, plus occupancy and sticky error status.
// The data/strobe widths must match the wbeat_t layout in idma_pkg.
module idma_wdata_buf
  import idma_pkg::*;
#(
  parameter int unsigned AXI_DATA_WID = AXI_DATA_WID_DFLT,
  parameter int unsigned AXI_STRBW    = AXI_DATA_WID / 8,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AF_MARGIN    = 2,
  parameter int unsigned CNTW         = $clog2(DEPTH + 1)
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    wr_cfg_init,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [AXI_DATA_WID-1:0] in_data,
  input  logic [AXI_STRBW-1:0]    in_strb,
  output logic                    wdata_fifo_empty_d,
  input  logic                    wdata_fifo_pop,
  output logic [AXI_DATA_WID-1:0] wdata_fifo_data_d,
  output logic [AXI_STRBW-1:0]    wdata_fifo_strb_d,
  output logic [CNTW-1:0]         fifo_cnt,
  output logic                    almost_full,
  output logic                    ovf_err,
  output logic                    udf_err
);

  localparam int unsigned     ENTRIES   = DEPTH - 1;
  localparam int unsigned     PTRW      = $clog2(ENTRIES);
  localparam logic [PTRW-1:0] PTR_LAST  = PTRW'(ENTRIES - 1);
  localparam logic [CNTW-1:0] CNT_FULL  = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] ARR_FULL  = CNTW'(ENTRIES);
  localparam logic [CNTW-1:0] AF_LEVEL  = CNTW'(DEPTH - AF_MARGIN);

  // Array pointers wrap at ENTRIES, which is not a power of two.
  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTRW'(1);
  endfunction

  logic [PTRW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTRW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNTW-1:0] arr_cnt_reg, arr_cnt_next;
  logic [CNTW-1:0] cnt_reg, cnt_next;
  logic            head_valid_reg;
  wbeat_t          head_reg;
  logic            af_reg;
  logic            ovf_reg;
  logic            udf_reg;

  logic   push, pop, head_take, arr_empty;
  logic   arr_rd, arr_wr, bypass, ovf_hit;
  wbeat_t in_beat, arr_rdata;

  // Handshake decode and head-refill selection.
  always_comb begin
    push         = in_valid & in_ready;
    pop          = wdata_fifo_pop & head_valid_reg;
    in_beat.data = in_data;
    in_beat.strb = in_strb;
    arr_empty    = (arr_cnt_reg == '0);
    // Head needs a new beat when it is empty or being consumed.
    head_take    = ~head_valid_reg | pop;
    arr_rd       = head_take & ~arr_empty;
    // With nothing older queued, the incoming beat goes straight to the head.
    bypass       = head_take & arr_empty & push;
    arr_wr       = push & ~bypass;
    // Cannot happen while in_ready tracks the total count; kept as a guard.
    ovf_hit      = arr_wr & ~arr_rd & (arr_cnt_reg == ARR_FULL);

    rd_ptr_next  = arr_rd ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    wr_ptr_next  = arr_wr ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;

    arr_cnt_next = arr_cnt_reg;
    if (arr_wr && !arr_rd) begin
      arr_cnt_next = arr_cnt_reg + CNTW'(1);
    end else if (arr_rd && !arr_wr) begin
      arr_cnt_next = arr_cnt_reg - CNTW'(1);
    end

    cnt_next = cnt_reg;
    if (push && !pop) begin
      cnt_next = cnt_reg + CNTW'(1);
    end else if (pop && !push) begin
      cnt_next = cnt_reg - CNTW'(1);
    end
  end

  idma_fifo_mem #(
    .ENTRIES (ENTRIES),
    .AW      (PTRW)
  ) u_mem (
    .clk   (aclk),
    .we    (arr_wr & ~wr_cfg_init),
    .waddr (wr_ptr_reg),
    .wdata (in_beat),
    .raddr (rd_ptr_reg),
    .rdata (arr_rdata)
  );

  // Pointer, count, head and status registers; a flush keeps the head data.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      arr_cnt_reg    <= '0;
      cnt_reg        <= '0;
      head_valid_reg <= 1'b0;
      head_reg       <= '0;
      af_reg         <= 1'b0;
      ovf_reg        <= 1'b0;
      udf_reg        <= 1'b0;
    end else if (wr_cfg_init) begin
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      arr_cnt_reg    <= '0;
      cnt_reg        <= '0;
      head_valid_reg <= 1'b0;
      af_reg         <= 1'b0;
      ovf_reg        <= 1'b0;
      udf_reg        <= 1'b0;
    end else begin
      rd_ptr_reg  <= rd_ptr_next;
      wr_ptr_reg  <= wr_ptr_next;
      arr_cnt_reg <= arr_cnt_next;
      cnt_reg     <= cnt_next;
      af_reg      <= (cnt_next >= AF_LEVEL);
      ovf_reg     <= ovf_reg | ovf_hit;
      udf_reg     <= udf_reg | (wdata_fifo_pop & ~head_valid_reg);
      if (arr_rd) begin
        head_reg       <= arr_rdata;
        head_valid_reg <= 1'b1;
      end else if (bypass) begin
        head_reg       <= in_beat;
        head_valid_reg <= 1'b1;
      end else if (head_take) begin
        head_valid_reg <= 1'b0;
      end
    end
  end

  assign in_ready           = (cnt_reg < CNT_FULL);
  assign wdata_fifo_empty_d = ~head_valid_reg;
  assign wdata_fifo_data_d  = head_reg.data;
  assign wdata_fifo_strb_d  = head_reg.strb;
  assign fifo_cnt           = cnt_reg;
  assign almost_full        = af_reg;
  assign ovf_err            = ovf_reg;
  assign udf_err            = udf_reg;

endmodule

// File: tb/tb_idma_wdata_buf.sv
// Testbench for idma_wdata_buf: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based FIFO reference model.
module tb_idma_wdata_buf;

  localparam int DW    = 256;
  localparam int SW    = 32;
  localparam int DEPTH = 16;
  localparam int CNTW  = 5;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic            wr_cfg_init = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_data = '0;
  logic [SW-1:0]   in_strb = '0;
  logic            wdata_fifo_empty_d;
  logic            wdata_fifo_pop = 1'b0;
  logic [DW-1:0]   wdata_fifo_data_d;
  logic [SW-1:0]   wdata_fifo_strb_d;
  logic [CNTW-1:0] fifo_cnt;
  logic            almost_full;
  logic            ovf_err;
  logic            udf_err;

  idma_wdata_buf #(
    .AXI_DATA_WID (DW),
    .AXI_STRBW    (SW),
    .DEPTH        (DEPTH),
    .AF_MARGIN    (2),
    .CNTW         (CNTW)
  ) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .wr_cfg_init        (wr_cfg_init),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_data            (in_data),
    .in_strb            (in_strb),
    .wdata_fifo_empty_d (wdata_fifo_empty_d),
    .wdata_fifo_pop     (wdata_fifo_pop),
    .wdata_fifo_data_d  (wdata_fifo_data_d),
    .wdata_fifo_strb_d  (wdata_fifo_strb_d),
    .fifo_cnt           (fifo_cnt),
    .almost_full        (almost_full),
    .ovf_err            (ovf_err),
    .udf_err            (udf_err)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of {data,strb} beats, head is element 0.
  logic [DW+SW-1:0] mdl_q[$];
  logic [DW+SW-1:0] mdl_last = '0;
  bit               mdl_udf = 1'b0;

  task automatic chk(input string tag, input logic [DW+SW-1:0] obs, input logic [DW+SW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("empty_d", (DW+SW)'(wdata_fifo_empty_d), (DW+SW)'(mdl_q.size() == 0));
    chk("head",    {wdata_fifo_data_d, wdata_fifo_strb_d}, mdl_last);
    chk("cnt",     (DW+SW)'(fifo_cnt), (DW+SW)'(mdl_q.size()));
    chk("in_ready",(DW+SW)'(in_ready), (DW+SW)'(mdl_q.size() < DEPTH));
    chk("almost_full", (DW+SW)'(almost_full), (DW+SW)'(mdl_q.size() >= DEPTH - 2));
    chk("ovf_err", (DW+SW)'(ovf_err), '0);
    chk("udf_err", (DW+SW)'(udf_err), (DW+SW)'(mdl_udf));
  endtask

  // One cycle: check outputs settled from the last edge, drive new inputs,
  // then advance the model to the state expected after the coming edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic [SW-1:0] s,
                      input logic p, input logic init);
    bit push_ok;
    bit pop_ok;
    @(negedge aclk);
    check_all();
    in_valid       = v;
    in_data        = d;
    in_strb        = s;
    wdata_fifo_pop = p;
    wr_cfg_init    = init;
    $display("step v=%0b p=%0b init=%0b cnt=%0d data=%0h", v, p, init, mdl_q.size(), d[31:0]);
    if (init) begin
      mdl_q.delete();
      mdl_udf = 1'b0;
    end else begin
      push_ok = v && (mdl_q.size() < DEPTH);
      pop_ok  = p && (mdl_q.size() > 0);
      if (p && mdl_q.size() == 0) mdl_udf = 1'b1;
      if (pop_ok) void'(mdl_q.pop_front());
      if (push_ok) mdl_q.push_back({d, s});
    end
    if (mdl_q.size() > 0) mdl_last = mdl_q[0];
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int k = 0; k < DW/32; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn        = 1'b0;
    in_valid       = 1'b0;
    wdata_fifo_pop = 1'b0;
    wr_cfg_init    = 1'b0;
    mdl_q.delete();
    mdl_udf  = 1'b0;
    mdl_last = '0;
    #2;
    aresetn = 1'b1;
    $display("reset applied");
  endtask

  initial begin
    logic [DW-1:0] a5;
    logic          pv;
    logic          pp;
    int            push_pct;
    int            pop_pct;

    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;

    // Single beat in and out.
    a5 = {(DW/8){8'hA5}};
    step(1'b1, a5, '1, 1'b0, 1'b0);
    idle(1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    idle(2);

    // Fill to full, then drain one per cycle.
    for (int k = 0; k < DEPTH; k++) step(1'b1, DW'(k), SW'(k * 3), 1'b0, 1'b0);
    step(1'b1, {DW{1'b1}}, '1, 1'b0, 1'b0);      // refused while full
    for (int k = 0; k < DEPTH; k++) step(1'b0, '0, '0, 1'b1, 1'b0);
    idle(1);

    // Streaming at occupancy 1.
    step(1'b1, rnd_data(), SW'($urandom()), 1'b0, 1'b0);
    for (int k = 0; k < 100; k++) step(1'b1, rnd_data(), SW'($urandom()), 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    idle(1);

    // Underflow sets a sticky flag that only a flush clears.
    step(1'b0, '0, '0, 1'b1, 1'b0);
    idle(3);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    idle(1);

    // Flush with a simultaneous push and pop discards both.
    for (int k = 0; k < 10; k++) step(1'b1, rnd_data(), SW'($urandom()), 1'b0, 1'b0);
    step(1'b1, {(DW/32){32'hDEADBEEF}}, '1, 1'b1, 1'b1);
    idle(1);
    step(1'b1, rnd_data(), SW'($urandom()), 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    idle(1);

    // Reset mid-transfer drops held beats.
    for (int k = 0; k < 5; k++) step(1'b1, rnd_data(), SW'($urandom()), 1'b0, 1'b0);
    do_reset();
    idle(1);

    // Randomized traffic with varying push/pop pressure to exercise wrap.
    push_pct = 50;
    pop_pct  = 50;
    for (int k = 0; k < 1000; k++) begin
      if (k % 100 == 0) begin
        push_pct = int'($urandom_range(20, 95));
        pop_pct  = int'($urandom_range(20, 95));
      end
      pv = ($urandom_range(0, 99) < push_pct);
      pp = ($urandom_range(0, 99) < pop_pct);
      step(pv, rnd_data(), SW'($urandom()), pp, ($urandom_range(0, 199) == 0));
    end
    idle(1);
    @(negedge aclk);
    check_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
